// File: rtl/mmio_pkg.sv
// Shared constants and types for the 16-bit memory-mapped parallel port.
package mmio_pkg;

    localparam int PORT_W = 16;

    typedef logic [PORT_W-1:0] port_t;

    // Byte offsets inside the 256-byte window.
    localparam logic [7:0] OFF_OUT  = 8'h00;
    localparam logic [7:0] OFF_SET  = 8'h04;
    localparam logic [7:0] OFF_CLR  = 8'h08;
    localparam logic [7:0] OFF_IN   = 8'h0C;
    localparam logic [7:0] OFF_EDGE = 8'h10;
    localparam logic [7:0] OFF_IEN  = 8'h14;

    // New output-register value for a store of wdata at byte offset off.
    function automatic port_t out_after_store(input port_t cur, input logic [7:0] off,
                                              input port_t wdata);
        port_t nxt;
        nxt = cur;
        case (off)
            OFF_OUT: nxt = wdata;
            OFF_SET: nxt = cur | wdata;
            OFF_CLR: nxt = cur & ~wdata;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sync2.sv
// Parameterized-width two-flop synchronizer with asynchronous active-low reset.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/mmio_port16.sv
// Memory-mapped 16-bit parallel I/O port on the core data bus.
// Optional change-detect interrupt enabled by defining MMIO_PORT16_IRQ_EN.
module mmio_port16
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter port_t       OUT_RESET = 16'h0000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] daddr,
    input  logic [31:0] ddata_w,
    input  logic        d_rw,
    output logic [31:0] ddata_r,
    output logic [15:0] DOUT,
    input  logic [15:0] DIN,
    output logic        irq
);

    logic       sel;
    logic       wr;
    logic [7:0] off;
    port_t      wdata;
    port_t      out_q;
    port_t      out_d;
    port_t      in_s2;
    port_t      rd_val;
    logic       unused_bits;

    assign sel   = (daddr[31:8] == BASE_ADDR[31:8]);
    assign wr    = sel && d_rw;
    assign off   = {daddr[7:2], 2'b00};
    assign wdata = ddata_w[PORT_W-1:0];

    // Byte lane and upper store data are don't-care on this port.
    assign unused_bits = &{1'b0, ddata_w[31:16], daddr[1:0]};

    sync2 #(.W(PORT_W)) u_din_sync (
        .clk_i  (CLK),
        .rst_ni (RESET_N),
        .d_i    (DIN),
        .q_o    (in_s2)
    );

    always_comb begin
        out_d = out_q;
        if (wr) begin
            out_d = out_after_store(out_q, off, wdata);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_q <= OUT_RESET;
        end else begin
            out_q <= out_d;
        end
    end

`ifdef MMIO_PORT16_IRQ_EN
    port_t s3_q;
    port_t edge_q;
    port_t edge_d;
    port_t ien_q;
    port_t ien_d;
    port_t w1c;
    logic  irq_q;

    // A change arriving together with its W1C keeps the bit set.
    always_comb begin
        w1c   = (wr && off == OFF_EDGE) ? wdata : '0;
        edge_d = (edge_q & ~w1c) | (in_s2 ^ s3_q);
        ien_d = (wr && off == OFF_IEN) ? wdata : ien_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s3_q   <= '0;
            edge_q <= '0;
            ien_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            s3_q   <= in_s2;
            edge_q <= edge_d;
            ien_q  <= ien_d;
            irq_q  <= |(edge_q & ien_q);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_OUT:  rd_val = out_q;
            OFF_IN:   rd_val = in_s2;
`ifdef MMIO_PORT16_IRQ_EN
            OFF_EDGE: rd_val = edge_q;
            OFF_IEN:  rd_val = ien_q;
`else
            OFF_EDGE, OFF_IEN: rd_val = '0;
`endif
            default:  rd_val = '0;
        endcase
    end

    assign ddata_r = (sel && !d_rw) ? {16'h0000, rd_val} : 32'h0000_0000;
    assign DOUT    = out_q;

endmodule
